// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared widths and FSM state encodings for the SRAM bridge
package sram_controller_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int SRAM_DATA_WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: counts the cycles of one SRAM half-word phase and flags its final cycle
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           en,
  output logic [$clog2(WAIT_CYCLES)-1:0] count,
  output logic                           last
);
  localparam int CW = $clog2(WAIT_CYCLES);
  assign last = count == CW'(WAIT_CYCLES - 1);
  // clear wins over enable so a phase boundary restarts from zero
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit MEM-stage access split into two timed 16-bit SRAM phases; SRAM_ADDR_REBASE_EN subtracts BASE_ADDR
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int BASE_ADDR = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [WORD_WIDTH-1:0]      address,
  input  logic [WORD_WIDTH-1:0]      write_data,
  output logic [WORD_WIDTH-1:0]      read_data,
  output logic                       ready,
  inout  wire  [SRAM_DATA_WIDTH-1:0] sram_dq,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_we_n,
  output logic                       sram_oe_n,
  output logic                       sram_ce_n
);
  localparam int CW = $clog2(WAIT_CYCLES);
`ifdef SRAM_ADDR_REBASE_EN
  localparam bit REBASE = 1'b1;
`else
  localparam bit REBASE = 1'b0;
`endif
  state_t state;
  logic [CW-1:0] count;
  logic last, pre_last, is_wr, dq_en, unused_bits;
  logic [WORD_WIDTH-1:0] eff_addr;
  logic [SRAM_ADDR_WIDTH-2:0] w, word;
  logic [SRAM_DATA_WIDTH-1:0] wdata_hi, lo_q, dq_out;
  assign eff_addr = REBASE ? address - WORD_WIDTH'(BASE_ADDR) : address;
  assign w = eff_addr[SRAM_ADDR_WIDTH:2];
  assign unused_bits = ^{eff_addr[1:0], eff_addr[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1]};
  assign pre_last = count == CW'(WAIT_CYCLES - 2);
  assign ready = ~(rd_en | wr_en) | (state == DONE);
  assign sram_dq = dq_en ? dq_out : 'z;
  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear((state == IDLE) | last),
    .en((state == LOW) | (state == HIGH)),
    .count(count),
    .last(last)
  );
  // access FSM; every SRAM pin is registered and computed one cycle ahead, so we_n rises on each phase's last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      is_wr <= 1'b0;
      word <= '0;
      wdata_hi <= '0;
      lo_q <= '0;
      read_data <= '0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      dq_en <= 1'b0;
      dq_out <= '0;
    end else begin
      case (state)
        IDLE: if (wr_en || rd_en) begin
          state <= LOW;
          is_wr <= wr_en;
          word <= w;
          wdata_hi <= write_data[31:16];
          sram_addr <= {w, 1'b0};
          sram_ce_n <= 1'b0;
          sram_oe_n <= wr_en;
          sram_we_n <= ~wr_en;
          dq_en <= wr_en;
          dq_out <= write_data[15:0];
        end
        LOW: if (last) begin
          state <= HIGH;
          lo_q <= sram_dq;
          sram_addr <= {word, 1'b1};
          sram_we_n <= ~is_wr;
          dq_out <= wdata_hi;
        end else sram_we_n <= ~is_wr | pre_last;
        HIGH: if (last) begin
          state <= DONE;
          read_data <= is_wr ? read_data : {sram_dq, lo_q};
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_ce_n <= 1'b1;
          dq_en <= 1'b0;
        end else sram_we_n <= ~is_wr | pre_last;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench with a behavioural async SRAM on the 16-bit bus
module tb_sram_controller;
  localparam int WAIT = 5;
  localparam int AW = 18;
`ifdef SRAM_ADDR_REBASE_EN
  localparam logic [31:0] B = 32'd1024;
`else
  localparam logic [31:0] B = 32'd0;
`endif
  typedef struct {bit wr; logic [31:0] data; int idx;} exp_t;
  logic clk = 1'b0, rst = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic ready, we_n, oe_n, ce_n;
  logic [AW-1:0] sram_addr;
  wire [15:0] sram_dq;
  logic [15:0] mem [0:(1<<AW)-1];
  exp_t sb[$];
  int vectors = 0, miscompares = 0, busy = 0, cyc_now = 0;
  int rdy_cyc, oe_low, we_low, we_after_rst, rdy_abs, prev_abs;
  logic [AW-1:0] a_lo, a_hi;
  sram_controller #(.WAIT_CYCLES(WAIT), .SRAM_ADDR_WIDTH(AW), .BASE_ADDR(1024)) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_dq(sram_dq),
    .sram_addr(sram_addr),
    .sram_we_n(we_n),
    .sram_oe_n(oe_n),
    .sram_ce_n(ce_n)
  );
  always #5 clk = ~clk;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 'z;
  always @(negedge clk) begin
    cyc_now++;
    if (!ce_n && !we_n) mem[sram_addr] = sram_dq;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // monitor: every completed access pops the scoreboard and checks latency and data
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy = 0;
    else if (rd_en || wr_en) begin
      if (!ready) busy++;
      else begin
        if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("latency", busy, 32'd11);
          if (e.wr) begin
            chk("mem_lo", {16'h0, mem[e.idx]}, {16'h0, e.data[15:0]});
            chk("mem_hi", {16'h0, mem[e.idx+1]}, {16'h0, e.data[31:16]});
          end else chk("read_data", read_data, e.data);
        end
        busy = 0;
      end
    end
  end
  task automatic access(input bit wr, input logic [31:0] off, input logic [31:0] d, input int rst_at);
    exp_t e;
    @(posedge clk); #1;
    wr_en = wr; rd_en = ~wr; address = B + off; write_data = wr ? d : 32'h5555_AAAA;
    e.wr = wr; e.data = d; e.idx = int'(off >> 1);
    sb.push_back(e);
    rdy_cyc = -1; oe_low = 0; we_low = 0; a_lo = '0; a_hi = '0; we_after_rst = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!oe_n) oe_low++;
      if (!we_n) we_low++;
      if (c == 1) a_lo = sram_addr;
      if (c == WAIT + 1) a_hi = sram_addr;
      if (c == rst_at + 1) we_after_rst = {31'd0, we_n} + {30'd0, ce_n, 1'b0};
      if (ready) begin rdy_cyc = c; rdy_abs = cyc_now; break; end
      @(posedge clk); #1;
      rst = (c + 1 == rst_at);
    end
    if (rdy_cyc < 0) chk("timeout", 32'd1, 32'd0);
  endtask
  task automatic go_idle();
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_ctrl", {29'd0, we_n, oe_n, ce_n}, 32'd7);
    access(1'b1, 32'd0, 32'hDEADBEEF, -1);
    chk("wr_ready_cycle", rdy_cyc, 32'd11);
    chk("wr_we_low", we_low, 32'd8);
    chk("wr_oe_low", oe_low, 32'd0);
    chk("wr_addr_lo", {14'd0, a_lo}, 32'd0);
    chk("wr_addr_hi", {14'd0, a_hi}, 32'd1);
    go_idle();
    access(1'b0, 32'd0, 32'hDEADBEEF, -1);
    chk("rd_ready_cycle", rdy_cyc, 32'd11);
    chk("rd_oe_low", oe_low, 32'd10);
    chk("rd_we_low", we_low, 32'd0);
    go_idle();
    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_ctrl", {29'd0, we_n, oe_n, ce_n}, 32'd7);
    access(1'b1, 32'd4, 32'h12345678, -1);
    go_idle();
    access(1'b0, 32'd0, 32'hDEADBEEF, -1);
    prev_abs = rdy_abs;
    access(1'b0, 32'd4, 32'h12345678, -1);
    chk("b2b_addr_lo", {14'd0, a_lo}, 32'd2);
    chk("b2b_addr_hi", {14'd0, a_hi}, 32'd3);
    chk("b2b_gap", rdy_abs - prev_abs, 32'd12);
    go_idle();
    access(1'b1, 32'd8, 32'h0BADF00D, -1);
    go_idle();
    @(negedge clk);
    chk("read_data_hold", read_data, 32'h12345678);
    access(1'b0, 32'd8, 32'h0BADF00D, -1);
    chk("rd8_addr_lo", {14'd0, a_lo}, 32'd4);
    chk("rd8_addr_hi", {14'd0, a_hi}, 32'd5);
    go_idle();
    access(1'b1, 32'd12, 32'hCAFEF00D, 4);
    chk("rst_abort_ctrl", we_after_rst, 32'd3);
    chk("rst_restart_cycle", rdy_cyc, 32'd16);
    go_idle();
    access(1'b0, 32'd12, 32'hCAFEF00D, -1);
    go_idle();
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
